rr_arbiter_n: RTL and testbench

Parametrised, registered round-robin arbiter that succeeds the fixed four-requester arbiter. It adds:
- a configurable requester count;
- per-requester weights, so a winner holds the grant for several consecutive cycles;
- a lock input for multi-cycle transfers;
- a grant-valid/grant-index output alongside the one-hot grant vector.

It sits between N request sources and one shared resource, and is the arbiter instantiated by every shared-resource block that follows.

---
 rtl/rr_arbiter_n_if.sv | 18 +
 rtl/rr_arbiter_n.sv | 97 +++++++++
 tb/tb_rr_arbiter_n.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The master side drives requests, weights and lock; the slave side returns the grant.
interface rr_arbiter_n_if #(
    parameter int N  = 4,
    parameter int WW = 2
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            lock;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;

    modport master (output req, weight, lock, input gnt, gnt_valid, gnt_id);
    modport slave  (input req, weight, lock, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/rr_arbiter_n.sv
// Registered weighted round-robin arbiter for N requesters with a lock input.
// The winner keeps the grant for weight+1 cycles, or indefinitely while lock is high.
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int WW = 2
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);
    localparam int IW  = $clog2(N);
    localparam int IW1 = IW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [WW-1:0]   credit_q, credit_d;
    logic [N-1:0]    gnt_q, gnt_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW1-1:0]  idx;
    logic [N-1:0]    win_onehot;
    logic            hold;

    // Rotating search from ptr; the sum stays below 2N, so one subtraction wraps it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + IW1'(k);
            if (idx >= IW1'(N)) begin
                idx = idx - IW1'(N);
            end
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win == IW'(gi));
        end
    endgenerate

    assign hold = (state_q == GRANT) && bus.req[owner_q] &&
                  (bus.lock || (credit_q != '0));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        credit_d = credit_q;
        gnt_d    = gnt_q;
        if (hold) begin
            if (!bus.lock) begin
                credit_d = credit_q - 1'b1;
            end
        end else if (found) begin
            state_d  = GRANT;
            owner_d  = win;
            gnt_d    = win_onehot;
            credit_d = bus.weight[win*WW +: WW];
            ptr_d    = (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end else begin
            // Nobody requesting: ptr and credit deliberately keep their values.
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt_id    = owner_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: N=4 and N=5 instances checked every cycle against a
// term-counting reference model, plus directed grant sequences.
module tb_rr_arbiter_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter_n_if #(.N(4), .WW(2)) bus4 ();
    rr_arbiter_n_if #(.N(5), .WW(2)) bus5 ();

    rr_arbiter_n #(.N(4), .WW(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rr_arbiter_n #(.N(5), .WW(2)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner (-1 = none), granted term length, unlocked cycles used so far, search start.
    int m_own  [2];
    int m_term [2];
    int m_used [2];
    int m_ptr  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_own[u]  = -1;
            m_term[u] = 0;
            m_used[u] = 0;
            m_ptr[u]  = 0;
        end
    endtask

    task automatic model_step(input int u, input int n, input logic [31:0] rq,
                              input logic [63:0] wts, input logic lk);
        int pick;
        if (m_own[u] >= 0 && rq[m_own[u]] && (lk || m_used[u] < m_term[u])) begin
            if (!lk) m_used[u]++;
        end else begin
            pick = -1;
            for (int k = 0; k < n; k++) begin
                if (pick < 0 && rq[(m_ptr[u] + k) % n]) pick = (m_ptr[u] + k) % n;
            end
            if (pick >= 0) begin
                m_own[u]  = pick;
                m_term[u] = int'((wts >> (2 * pick)) & 64'd3);
                m_used[u] = 0;
                m_ptr[u]  = (pick + 1) % n;
            end else begin
                m_own[u] = -1;
            end
        end
    endtask

    task automatic model_check(input int u, input logic [31:0] g, input logic v, input logic [31:0] id);
        logic [31:0] eg;
        eg = (m_own[u] >= 0) ? (32'd1 << m_own[u]) : 32'd0;
        chk((u == 0) ? "model_gnt4"   : "model_gnt5", g, eg);
        chk((u == 0) ? "model_valid4" : "model_valid5", {31'd0, v}, {31'd0, m_own[u] >= 0});
        chk((u == 0) ? "model_id4"    : "model_id5", id, (m_own[u] >= 0) ? m_own[u] : 0);
        chk((u == 0) ? "onehot4"      : "onehot5", {31'd0, $onehot0(g)}, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, {28'd0, bus4.req}, {56'd0, bus4.weight}, bus4.lock);
        model_step(1, 5, {27'd0, bus5.req}, {54'd0, bus5.weight}, bus5.lock);
        #1;
        $display("t=%0t req4=%h lock4=%b gnt4=%h id4=%0d | req5=%h lock5=%b gnt5=%h id5=%0d",
                 $time, bus4.req, bus4.lock, bus4.gnt, bus4.gnt_id,
                 bus5.req, bus5.lock, bus5.gnt, bus5.gnt_id);
        model_check(0, {28'd0, bus4.gnt}, bus4.gnt_valid, {30'd0, bus4.gnt_id});
        model_check(1, {27'd0, bus5.gnt}, bus5.gnt_valid, {29'd0, bus5.gnt_id});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt4"},   {28'd0, bus4.gnt}, 32'd0);
        chk({tag, "_valid4"}, {31'd0, bus4.gnt_valid}, 32'd0);
        chk({tag, "_id4"},    {30'd0, bus4.gnt_id}, 32'd0);
        chk({tag, "_gnt5"},   {27'd0, bus5.gnt}, 32'd0);
        chk({tag, "_valid5"}, {31'd0, bus5.gnt_valid}, 32'd0);
    endtask

    // Called off-edge: pulse reset asynchronously and check outputs clear without a clock.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_idle("async_rst");
        model_reset();
        rst = 1'b1;
    endtask

    task automatic step4(input string tag, input logic [3:0] rq, input logic lk,
                         input int exp_id, input logic exp_v);
        bus4.req  = rq;
        bus4.lock = lk;
        tick();
        chk({tag, "_valid"}, {31'd0, bus4.gnt_valid}, {31'd0, exp_v});
        chk({tag, "_id"}, {30'd0, bus4.gnt_id}, exp_id);
        chk({tag, "_gnt"}, {28'd0, bus4.gnt}, exp_v ? (32'd1 << exp_id) : 32'd0);
    endtask

    initial begin
        int exp_w [9];
        exp_w = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

        bus4.req = '0; bus4.weight = '0; bus4.lock = 1'b0;
        bus5.req = '0; bus5.weight = '0; bus5.lock = 1'b0;
        model_reset();
        #3;
        chk_idle("reset");
        rst = 1'b1;

        // Plain round robin on both sizes; N=5 wraps 4 -> 0.
        bus4.req = 4'hF;
        bus5.req = 5'h1F;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr4_id", {30'd0, bus4.gnt_id}, i % 4);
            chk("rr5_id", {29'd0, bus5.gnt_id}, i % 5);
        end

        do_reset();
        bus4.weight = 8'b00_00_00_10;
        for (int i = 0; i < 9; i++) step4("weighted", 4'hF, 1'b0, exp_w[i], 1'b1);

        do_reset();
        bus4.weight = 8'b00_11_00_00;
        step4("early_a", 4'b0100, 1'b0, 2, 1'b1);
        step4("early_b", 4'b0111, 1'b0, 2, 1'b1);
        step4("early_c", 4'b0011, 1'b0, 0, 1'b1);
        step4("early_d", 4'b0000, 1'b0, 0, 1'b0);

        do_reset();
        bus4.weight = 8'd0;
        step4("lock_win", 4'b0010, 1'b0, 1, 1'b1);
        for (int i = 0; i < 5; i++) step4("lock_hold", 4'hF, 1'b1, 1, 1'b1);
        step4("lock_rel", 4'hF, 1'b0, 2, 1'b1);

        do_reset();
        bus4.weight = 8'b00_00_00_01;
        for (int i = 0; i < 6; i++) step4("sole", 4'b0001, 1'b0, 0, 1'b1);
        #2;
        do_reset();
        step4("sole_after_rst", 4'b0001, 1'b0, 0, 1'b1);

        // Randomized traffic with sticky requests, occasional weight changes and lock.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) bus4.req = 4'($urandom);
            if ($urandom_range(0, 2) == 0) bus5.req = 5'($urandom);
            if ($urandom_range(0, 4) == 0) bus4.weight = 8'($urandom);
            if ($urandom_range(0, 4) == 0) bus5.weight = 10'($urandom);
            bus4.lock = ($urandom_range(0, 3) == 0);
            bus5.lock = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
